dmem_unit: RTL and testbench
============================

# dmem_unit

Parametrised, handshaked data memory for the single-cycle/multi-cycle MIPS datapath, replacing the fixed 32-word store. Accepts byte-addressed MIPS loads/stores (LB/LBU/LH/LHU/LW/SB/SH/SW) over a valid/ready request channel. Performs lane alignment, byte-enable generation, sign extension and misalignment checking internally. Returns results one cycle later, and zero-fills the whole array after every reset with an internal clear sequencer.

## Interface
Parameters:
- ADDR_W, 8, word-address bits; DEPTH = 2**ADDR_W words of 32 bits
- CLEAR_ON_RESET, 1, 1 = run zero-fill sequencer after reset; 0 = skip (array contents undefined at power-up, retained across reset)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse: response for the request accepted the previous cycle
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size request; no memory update
- busy  out  1  clear sequencer running
- test_addr  in  ADDR_W  debug word address (DMEM_TEST_PORT_EN only)
- test_data  out  32  debug word, combinational (DMEM_TEST_PORT_EN only)

## Operation
- FSM states: CLEAR, RUN. rst forces CLEAR with clear counter = 0. CLEAR writes word[cnt] = 0 and increments cnt each cycle; after cnt = DEPTH-1 it moves to RUN. With CLEAR_ON_RESET = 0, reset goes straight to RUN.
- Accept = req_valid && req_ready. req_ready = 1 only in RUN and not in rst. Back-to-back accepts every cycle are allowed; responses have no backpressure.
- Alignment check: half requires addr[0] = 0; word requires addr[1:0] = 0; size 3 is always an error. On error: no write, resp_err = 1, resp_rdata = 0.
- Store lanes: byte → wen = 1 << addr[1:0], data replicated ×4. Half → wen = addr[1] ? 4'b1100 : 4'b0011, data replicated ×2. Word → wen = 4'b1111. Byte lane k is data bits [8k+7:8k] (little-endian lanes).
- Load: selected lane(s) shifted to bit 0, then sign- or zero-extended per req_signed; req_signed is ignored for word loads.
- Stores respond with resp_valid = 1, resp_rdata = 0, resp_err = 0 (or err as above).
- Address wraps modulo DEPTH; no out-of-range error.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_rdata 0, resp_err 0, busy = CLEAR_ON_RESET.
- Clear: first cycle with rst = 0 clears word 0. req_ready rises and busy falls on the DEPTH-th cycle after rst deasserts.
- Store accepted in cycle N: memory is updated at the edge ending N; resp_valid is high in N+1.
- Load accepted in cycle N: synchronous array read at the edge ending N; resp_valid and resp_rdata are valid in N+1.
- Store in N followed by load of the same word in N+1 returns the new data (no bypass needed; the write completes first).
- rst mid-clear or mid-response: the response is dropped (resp_valid 0 next cycle) and the clear restarts from word 0.
- Requests presented while busy are not accepted and cause no side effects.

## Configuration
- DMEM_TEST_PORT_EN defined: test_addr/test_data ports exist. test_data = word[test_addr] combinationally, showing a store the cycle after its accept edge and reading 0 during/after clear for cleared words.
- Undefined: both ports are absent; no extra read port is inferred.

## Structure
- Package dmem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum (ST_CLEAR, ST_RUN), and the lane-enable function.
- Sub-module dmem_bank: DEPTH × 32 array with 4 byte-write enables, one synchronous read port, and the optional combinational test port. dmem_unit holds the FSM, clear counter, alignment/extension logic and response registers.

## Test plan
- Reset with ADDR_W = 4 → busy = 1 for 16 cycles, req_ready = 0 throughout; then LW at 0x3C → resp_rdata 0x00000000, resp_err 0.
- SW 0x8899AABB @0x10, then LB @0x11 signed → 0xFFFFFFAA; LBU @0x13 → 0x00000088; LH @0x12 signed → 0xFFFF8899.
- SB 0x7F @0x21, then SH 0x1234 @0x22, then LW @0x20 → 0x12347F00 (back-to-back accepts, one response per cycle).
- LW @0x06, SH @0x05, size 3 @0x00 → each returns resp_err = 1, rdata 0; a following LW @0x04 shows the word unchanged.
- Assert rst for 1 cycle midway through the clear and mid-response → resp_valid drops, and the clear restarts with a full DEPTH cycles before req_ready.
- With DMEM_TEST_PORT_EN: SW 0xDEADBEEF @ word 5, test_addr = 5 → test_data = 0xDEADBEEF from the cycle after accept.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the MIPS data memory unit.
// The optional debug read port is enabled by defining DMEM_TEST_PORT_EN.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  // Byte-write enables for a store of the given size at byte offset off.
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_en = 4'b0001 << off;
      SZ_HALF: lane_en = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 storage with byte-write enables and one synchronous read port.
// DMEM_TEST_PORT_EN adds a combinational debug read port.
module dmem_bank #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        wen,
  input  logic [31:0]       wdata,
  input  logic              ren,
  output logic [31:0]       rdata
`ifdef DMEM_TEST_PORT_EN
  ,
  input  logic [ADDR_W-1:0] test_addr,
  output logic [31:0]       test_data
`endif
);

  logic [31:0] mem [2**ADDR_W];

  // NOTE: the array has no reset; zeroing is done word by word by the clear sequencer.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wen[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
    if (ren) rdata <= mem[addr];
  end

`ifdef DMEM_TEST_PORT_EN
  assign test_data = mem[test_addr];
`endif

endmodule

// File: rtl/dmem_unit.sv
// Handshaked byte-addressed data memory: clear sequencer, lane alignment and load extension.
// Define DMEM_TEST_PORT_EN to expose the test_addr/test_data debug port.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
`ifdef DMEM_TEST_PORT_EN
  ,
  input  logic [ADDR_W-1:0] test_addr,
  output logic [31:0]       test_data
`endif
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_we, clr_last;
  logic              accept, req_err;
  logic [1:0]        off;
  logic [ADDR_W-1:0] bank_addr;
  logic [3:0]        bank_wen;
  logic [31:0]       bank_wdata, bank_rdata;
  logic              bank_ren;
  logic              rsp_load, rsp_signed;
  logic [1:0]        rsp_size, rsp_off;
  logic [31:0]       shifted, load_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    else     state <= state_nxt;
  end

  // NOTE: each combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_last) state_nxt = ST_RUN;
  end

  always_comb begin
    busy      = rst ? CLEAR_ON_RESET : (state == ST_CLEAR);
    req_ready = !rst && (state == ST_RUN);
    clr_we    = !rst && (state == ST_CLEAR);
  end

  assign clr_last = (clr_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst)         clr_cnt <= '0;
    else if (clr_we) clr_cnt <= clr_cnt + ADDR_W'(1);
  end

  assign off      = req_addr[1:0];
  assign accept   = req_valid && req_ready;
  assign req_err  = misaligned(req_size, off);
  assign bank_ren = accept && !req_we && !req_err;

  // Clear and request traffic never overlap, so one bank port serves both.
  always_comb begin
    bank_addr = clr_we ? clr_cnt : req_addr[ADDR_W+1:2];
    bank_wen  = 4'h0;
    if (clr_we)                          bank_wen = 4'hF;
    else if (accept && req_we && !req_err) bank_wen = lane_en(req_size, off);
    case (req_size)
      SZ_BYTE: bank_wdata = {4{req_wdata[7:0]}};
      SZ_HALF: bank_wdata = {2{req_wdata[15:0]}};
      default: bank_wdata = req_wdata;
    endcase
    if (clr_we) bank_wdata = '0;
  end

  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk       (clk),
    .addr      (bank_addr),
    .wen       (bank_wen),
    .wdata     (bank_wdata),
    .ren       (bank_ren),
    .rdata     (bank_rdata)
`ifdef DMEM_TEST_PORT_EN
    ,
    .test_addr (test_addr),
    .test_data (test_data)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rsp_load   <= 1'b0;
    end else begin
      resp_valid <= accept;
      resp_err   <= accept && req_err;
      rsp_load   <= bank_ren;
    end
    if (accept) begin
      rsp_size   <= req_size;
      rsp_signed <= req_signed;
      rsp_off    <= off;
    end
  end

  // Loaded lane is shifted to bit 0 and extended; word loads ignore the signed flag.
  always_comb begin
    shifted = bank_rdata >> {rsp_off, 3'b000};
    case (rsp_size)
      SZ_BYTE: load_data = {{24{rsp_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{rsp_signed & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
    resp_rdata = rsp_load ? load_data : '0;
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit (ADDR_W = 4) against a byte-array reference model.
// Exercises the debug port too when DMEM_TEST_PORT_EN is defined.
module tb_dmem_unit;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata, resp_rdata;
  logic        resp_valid, resp_err, busy;
`ifdef DMEM_TEST_PORT_EN
  logic [3:0]  test_addr;
  logic [31:0] test_data;
`endif

  dmem_unit #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
`ifdef DMEM_TEST_PORT_EN
    ,
    .test_addr  (test_addr),
    .test_data  (test_data)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference model: byte-addressed memory plus a count of remaining clear cycles.
  logic [7:0]  mb [64];
  int          clear_left;
  bit          pend_valid, pend_err;
  logic [31:0] pend_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(input logic [1:0] sz, input logic [5:0] a);
    int n;
    n = 1 << sz;
    return (sz == 2'd3) || ((int'(a) % n) != 0);
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [5:0] a, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) mb[int'(a) + i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sg, input logic [5:0] a);
    int     n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(mb[int'(a) + i]) << (8 * i));
    if (sg && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_word(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  // One clock cycle: drive at the falling edge, check #1 later, then advance a full cycle.
  task automatic step(input bit r, input bit v, input bit we, input logic [1:0] sz,
                      input bit sg, input logic [5:0] a, input logic [31:0] wd,
                      input bit use_want = 1'b0, input logic [31:0] want = 32'h0);
    bit acc, e;
    rst = r; req_valid = v; req_we = we; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd;
    #1;
    if (!r) begin
      check("resp_valid", 32'(resp_valid), 32'(pend_valid));
      if (pend_valid) begin
        check("resp_rdata", resp_rdata, pend_rdata);
        check("resp_err", 32'(resp_err), 32'(pend_err));
      end else if (clear_left > 0) begin
        check("reset_rdata", resp_rdata, 32'h0);
        check("reset_err", 32'(resp_err), 32'h0);
      end
    end
    check("req_ready", 32'(req_ready), 32'(!r && clear_left == 0));
    check("busy", 32'(busy), 32'(r || clear_left != 0));
    acc        = v && !r && clear_left == 0;
    pend_valid = acc;
    pend_err   = 1'b0;
    pend_rdata = 32'h0;
    if (acc) begin
      e        = m_err(sz, a);
      pend_err = e;
      if (!e) begin
        if (we) m_store(sz, a, wd);
        else    pend_rdata = use_want ? want : m_load(sz, sg, a);
      end
    end
    if (r) begin
      clear_left = DEPTH;
      for (int i = 0; i < 64; i++) mb[i] = 8'h00;
    end else if (clear_left > 0) begin
      clear_left--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic busy_step();
    step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 2'd2, 1'b0, 6'($urandom_range(0, 63)) & 6'h3C,
         $urandom);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [5:0]  a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef DMEM_TEST_PORT_EN
    test_addr = '0;
`endif
    pend_valid = 1'b0; pend_err = 1'b0; pend_rdata = '0;
    clear_left = DEPTH;
    for (int i = 0; i < 64; i++) mb[i] = 8'h00;
    @(posedge clk);
    @(negedge clk);

    // Reset, then a full clear with requests presented (and ignored) while busy.
    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 6'h00, 32'hFFFF_FFFF);
    repeat (DEPTH) busy_step();
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, 1'b1, 32'h0000_0000);

    // Word store then sub-word loads of each lane.
    step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 6'h10, 32'h8899_AABB);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 6'h11, 32'h0, 1'b1, 32'hFFFF_FFAA);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 6'h13, 32'h0, 1'b1, 32'h0000_0088);
    step(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 6'h12, 32'h0, 1'b1, 32'hFFFF_8899);

    // Byte and half merges into one word, read back next cycle.
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 6'h21, 32'hFFFF_FF7F);
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 6'h22, 32'hFFFF_1234);
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h20, 32'h0, 1'b1, 32'h1234_7F00);

    // Misaligned and illegal-size requests leave memory untouched.
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h06, 32'h0);
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 6'h05, 32'h0000_FFFF);
    step(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 6'h00, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h04, 32'h0, 1'b1, 32'h0000_0000);
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h00, 32'h0, 1'b1, 32'h0000_0000);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00, 32'h0);

`ifdef DMEM_TEST_PORT_EN
    test_addr = 4'd5;
    step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 6'h14, 32'hDEAD_BEEF);
    check("test_data", test_data, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00, 32'h0);
`endif

    // Reset while a response is outstanding, then reset partway through the clear.
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 1'b1, 32'h8899_AABB);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00, 32'h0);
    repeat (7) busy_step();
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 6'h10, 32'h0);
    repeat (DEPTH) busy_step();
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 1'b1, 32'h0000_0000);

    // Randomized traffic against the byte model.
    for (int n = 0; n < 400; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 6'($urandom_range(0, 63));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~6'((1 << sz) - 1);
`ifdef DMEM_TEST_PORT_EN
      test_addr = 4'($urandom_range(0, DEPTH - 1));
`endif
      step(1'b0, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), sz,
           1'($urandom_range(0, 1)), a, $urandom);
`ifdef DMEM_TEST_PORT_EN
      check("test_data_rand", test_data, m_word(int'(test_addr)));
`endif
    end
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
